// File: rtl/serdes_64b66b_pkg.sv
// Shared 64b/66b definitions used by the TX encoder and the RX decoder.
// Holds the encoder FSM state codes, the word classes produced by the TX
// classifier, sync headers, block type fields, control characters and the
// payload carried by error blocks.
package serdes_64b66b_pkg;

    // Encoder FSM state codes (visible on O_tx_encode_state).
    typedef enum logic [2:0] {
        C_TX_INT_ST = 3'd1,
        C_TX_S_ST   = 3'd2,
        C_TX_D_ST   = 3'd3,
        C_TX_T_ST   = 3'd4,
        C_TX_E_ST   = 3'd5,
        C_TX_I_ST   = 3'd6
    } tx_state_t;

    // Classes of an incoming 8-lane word.
    typedef enum logic [2:0] {
        C_CLS_X = 3'd0,
        C_CLS_S = 3'd1,
        C_CLS_D = 3'd2,
        C_CLS_T = 3'd3,
        C_CLS_I = 3'd4
    } tx_class_t;

    // Sync headers.
    localparam logic [1:0] C_SYNC_DATA = 2'b01;
    localparam logic [1:0] C_SYNC_CTRL = 2'b10;

    // Block type fields, carried in block bits [7:0] of control blocks.
    // Idle and error blocks share the same type field.
    localparam logic [7:0] C_TYPE_START = 8'h78;
    localparam logic [7:0] C_TYPE_TERM  = 8'hFF;
    localparam logic [7:0] C_TYPE_IDLE  = 8'h1E;

    // Control characters on the MAC/CPRI side.
    localparam logic [7:0] C_CHAR_START = 8'hFB;
    localparam logic [7:0] C_CHAR_TERM  = 8'hFD;
    localparam logic [7:0] C_CHAR_IDLE  = 8'h07;

    // Per-lane control masks for the legal word shapes.
    localparam logic [7:0] C_CTRL_DATA  = 8'h00;
    localparam logic [7:0] C_CTRL_START = 8'h01;
    localparam logic [7:0] C_CTRL_TERM  = 8'h80;
    localparam logic [7:0] C_CTRL_IDLE  = 8'hFF;

    // Error block payload: eight 7-bit error codes.
    localparam logic [55:0] C_ERR_PAYLOAD = {8{7'h1E}};

    // True while a frame is open (after S, before T).
    function automatic logic is_frame_state(input tx_state_t st);
        return (st == C_TX_S_ST) || (st == C_TX_D_ST);
    endfunction

endpackage

// File: rtl/serdes_64b66b_tx_classify.sv
// Combinational classifier for one 64-bit MAC/CPRI word.
// Ports:
//   data       - eight characters, lane 0 in bits [7:0]
//   ctrl       - per-lane control flags, bit i qualifies lane i
//   word_class - S, D, T, I or X (anything not matching a legal shape)
module serdes_64b66b_tx_classify
    import serdes_64b66b_pkg::*;
(
    input  logic [63:0] data,
    input  logic [7:0]  ctrl,
    output tx_class_t   word_class
);

    logic [7:0] lane_is_idle;

    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        assign lane_is_idle[gi] = (data[gi*8 +: 8] == C_CHAR_IDLE);
    end

    always_comb begin
        word_class = C_CLS_X;
        if (ctrl == C_CTRL_DATA) begin
            word_class = C_CLS_D;
        end else if ((ctrl == C_CTRL_START) && (data[7:0] == C_CHAR_START)) begin
            word_class = C_CLS_S;
        end else if ((ctrl == C_CTRL_TERM) && (data[63:56] == C_CHAR_TERM)) begin
            word_class = C_CLS_T;
        end else if ((ctrl == C_CTRL_IDLE) && (&lane_is_idle)) begin
            word_class = C_CLS_I;
        end
    end

endmodule

// File: rtl/serdes_64b66b_tx_encode.sv
// 64b/66b TX encoder: classifies each valid input word, runs the frame FSM
// and emits the 64-bit block plus 2-bit sync header two clocks later.
// Ports:
//   I_pcs_tx_clk        - TX PCS clock
//   I_pcs_tx_rst_n      - asynchronous active-low reset
//   I_tx_data/I_tx_ctrl - input word and per-lane control flags
//   I_tx_valid          - input qualifier; low = gearbox pause
//   O_tx_block          - block payload, type field in [7:0] for control blocks
//   O_tx_header         - sync header (01 data, 10 control)
//   O_tx_valid          - output qualifier, I_tx_valid delayed by two clocks
//   O_tx_encode_state   - current FSM state
//   O_tx_encode_err_cnt - count of emitted error blocks, wraps 255->0
module serdes_64b66b_tx_encode
    import serdes_64b66b_pkg::*;
(
    input  logic        I_pcs_tx_clk,
    input  logic        I_pcs_tx_rst_n,
    input  logic [63:0] I_tx_data,
    input  logic [7:0]  I_tx_ctrl,
    input  logic        I_tx_valid,
    output logic [63:0] O_tx_block,
    output logic [1:0]  O_tx_header,
    output logic        O_tx_valid,
    output logic [2:0]  O_tx_encode_state,
    output logic [7:0]  O_tx_encode_err_cnt
);

    tx_class_t   in_class;
    tx_class_t   s1_class_reg;
    logic [63:0] s1_data_reg;
    logic        s1_valid_reg;

    tx_state_t   state_reg;
    tx_state_t   state_next;
    logic [63:0] block_reg;
    logic [63:0] block_next;
    logic [1:0]  header_reg;
    logic [1:0]  header_next;
    logic        valid_reg;
    logic [7:0]  err_cnt_reg;

    serdes_64b66b_tx_classify u_classify (
        .data       (I_tx_data),
        .ctrl       (I_tx_ctrl),
        .word_class (in_class)
    );

    // Stage 1: capture the word and its class. Each stage carries its own
    // valid bit, so a pause freezes the data while the valid bit walks out
    // to O_tx_valid with the same two-clock delay as the data.
    always_ff @(posedge I_pcs_tx_clk or negedge I_pcs_tx_rst_n) begin
        if (!I_pcs_tx_rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= 64'h0;
            s1_class_reg <= C_CLS_X;
        end else begin
            s1_valid_reg <= I_tx_valid;
            if (I_tx_valid) begin
                s1_data_reg  <= I_tx_data;
                s1_class_reg <= in_class;
            end
        end
    end

    // Frame FSM. Outside a frame only S or I are legal; inside a frame only
    // D or T. Everything else, including illegal words, lands in E.
    always_comb begin
        state_next = C_TX_E_ST;
        if (is_frame_state(state_reg)) begin
            if (s1_class_reg == C_CLS_D) begin
                state_next = C_TX_D_ST;
            end else if (s1_class_reg == C_CLS_T) begin
                state_next = C_TX_T_ST;
            end
        end else begin
            if (s1_class_reg == C_CLS_S) begin
                state_next = C_TX_S_ST;
            end else if (s1_class_reg == C_CLS_I) begin
                state_next = C_TX_I_ST;
            end
        end
    end

    // The emitted block follows the state being entered, so an offending
    // word is replaced by an error block rather than passed through.
    always_comb begin
        block_next  = {C_ERR_PAYLOAD, C_TYPE_IDLE};
        header_next = C_SYNC_CTRL;
        case (state_next)
            C_TX_S_ST: block_next = {s1_data_reg[63:8], C_TYPE_START};
            C_TX_D_ST: begin
                block_next  = s1_data_reg;
                header_next = C_SYNC_DATA;
            end
            C_TX_T_ST: block_next = {s1_data_reg[55:0], C_TYPE_TERM};
            C_TX_I_ST: block_next = {56'h0, C_TYPE_IDLE};
            default: ;
        endcase
    end

    // Stage 2: state, output block and error counter advance together.
    always_ff @(posedge I_pcs_tx_clk or negedge I_pcs_tx_rst_n) begin
        if (!I_pcs_tx_rst_n) begin
            state_reg   <= C_TX_INT_ST;
            block_reg   <= 64'h0;
            header_reg  <= C_SYNC_CTRL;
            valid_reg   <= 1'b0;
            err_cnt_reg <= 8'h0;
        end else begin
            valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                state_reg  <= state_next;
                block_reg  <= block_next;
                header_reg <= header_next;
                if (state_next == C_TX_E_ST) begin
                    err_cnt_reg <= err_cnt_reg + 8'd1;
                end
            end
        end
    end

    assign O_tx_block          = block_reg;
    assign O_tx_header         = header_reg;
    assign O_tx_valid          = valid_reg;
    assign O_tx_encode_state   = state_reg;
    assign O_tx_encode_err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_serdes_64b66b_tx_encode.sv
// Bench for serdes_64b66b_tx_encode: directed frames, illegal sequences,
// pauses, counter wrap, mid-frame reset and a randomized word stream, all
// compared against a word-level reference model.
module tb_serdes_64b66b_tx_encode;

    localparam int ST_INT = 1;
    localparam int ST_S   = 2;
    localparam int ST_D   = 3;
    localparam int ST_T   = 4;
    localparam int ST_E   = 5;
    localparam int ST_I   = 6;

    localparam int K_S = 0;
    localparam int K_D = 1;
    localparam int K_T = 2;
    localparam int K_I = 3;
    localparam int K_X = 4;

    localparam logic [63:0] IDLE_WORD = {8{8'h07}};
    localparam logic [63:0] ERR_BLOCK = {{8{7'h1E}}, 8'h1E};

    logic        clk;
    logic        rst_n;
    logic [63:0] tx_data;
    logic [7:0]  tx_ctrl;
    logic        tx_valid;
    logic [63:0] o_block;
    logic [1:0]  o_header;
    logic        o_valid;
    logic [2:0]  o_state;
    logic [7:0]  o_err_cnt;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    typedef struct {
        logic        v;
        logic [63:0] blk;
        logic [1:0]  hdr;
        logic [2:0]  st;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        pipe[$];
    logic [1:0]  obs_hdr[$];

    // Reference model state
    int          m_state;
    logic [7:0]  m_cnt;
    logic [63:0] m_blk;
    logic [1:0]  m_hdr;

    serdes_64b66b_tx_encode dut (
        .I_pcs_tx_clk        (clk),
        .I_pcs_tx_rst_n      (rst_n),
        .I_tx_data           (tx_data),
        .I_tx_ctrl           (tx_ctrl),
        .I_tx_valid          (tx_valid),
        .O_tx_block          (o_block),
        .O_tx_header         (o_header),
        .O_tx_valid          (o_valid),
        .O_tx_encode_state   (o_state),
        .O_tx_encode_err_cnt (o_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.v   = 1'b0;
        e.blk = 64'h0;
        e.hdr = 2'b10;
        e.st  = 3'(ST_INT);
        e.cnt = 8'h0;
        return e;
    endfunction

    task automatic model_reset();
        m_state = ST_INT;
        m_cnt   = 8'h0;
        m_blk   = 64'h0;
        m_hdr   = 2'b10;
        pipe.delete();
        pipe.push_back(reset_exp());
        pipe.push_back(reset_exp());
    endtask

    function automatic int kind_of(input logic [63:0] d, input logic [7:0] c);
        if (c == 8'h00) return K_D;
        if (c == 8'h01 && d[7:0] == 8'hFB) return K_S;
        if (c == 8'h80 && d[63:56] == 8'hFD) return K_T;
        if (c == 8'hFF && d == IDLE_WORD) return K_I;
        return K_X;
    endfunction

    // Word-level rules: inside a frame only D/T continue it, outside a frame
    // only S/I are acceptable; anything else produces an error block.
    task automatic model_apply(input logic v, input logic [63:0] d, input logic [7:0] c,
                               output exp_t e);
        int  k;
        bit  in_frame;
        if (v) begin
            k        = kind_of(d, c);
            in_frame = (m_state == ST_S) || (m_state == ST_D);
            if (in_frame)
                m_state = (k == K_D) ? ST_D : (k == K_T) ? ST_T : ST_E;
            else
                m_state = (k == K_S) ? ST_S : (k == K_I) ? ST_I : ST_E;
            m_hdr = 2'b10;
            case (m_state)
                ST_S: m_blk = {d[63:8], 8'h78};
                ST_D: begin m_blk = d; m_hdr = 2'b01; end
                ST_T: m_blk = {d[55:0], 8'hFF};
                ST_I: m_blk = {56'h0, 8'h1E};
                default: begin m_blk = ERR_BLOCK; m_cnt = m_cnt + 8'd1; end
            endcase
        end
        e.v   = v;
        e.blk = m_blk;
        e.hdr = m_hdr;
        e.st  = 3'(m_state);
        e.cnt = m_cnt;
    endtask

    // One clock: check the output due from two steps ago, then drive a word.
    task automatic step(input string tag, input logic v, input logic [63:0] d,
                        input logic [7:0] c);
        exp_t e;
        exp_t n;
        @(negedge clk);
        e = pipe.pop_front();
        chk({tag, ".valid"},  64'(o_valid),   64'(e.v));
        chk({tag, ".block"},  o_block,        e.blk);
        chk({tag, ".header"}, 64'(o_header),  64'(e.hdr));
        chk({tag, ".state"},  64'(o_state),   64'(e.st));
        chk({tag, ".errcnt"}, 64'(o_err_cnt), 64'(e.cnt));
        if (o_valid) obs_hdr.push_back(o_header);
        tx_valid = v;
        tx_data  = d;
        tx_ctrl  = c;
        model_apply(v, d, c, n);
        pipe.push_back(n);
        txn++;
        $display("txn %0d %s v=%b ctrl=%h data=%h", txn, tag, v, c, d);
    endtask

    task automatic make_word(input int kind, output logic [63:0] d, output logic [7:0] c);
        logic [63:0] r;
        r = {$urandom, $urandom};
        case (kind)
            K_S: begin d = {r[63:8], 8'hFB}; c = 8'h01; end
            K_D: begin d = r; c = 8'h00; end
            K_T: begin d = {8'hFD, r[55:0]}; c = 8'h80; end
            K_I: begin d = IDLE_WORD; c = 8'hFF; end
            default: begin d = r; c = 8'($urandom); end
        endcase
    endtask

    task automatic send(input string tag, input int kind);
        logic [63:0] d;
        logic [7:0]  c;
        make_word(kind, d, c);
        step(tag, 1'b1, d, c);
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) step("flush", 1'b0, IDLE_WORD, 8'hFF);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        tx_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk({tag, ".rst_valid"},  64'(o_valid),   64'd0);
        chk({tag, ".rst_block"},  o_block,        64'h0);
        chk({tag, ".rst_header"}, 64'(o_header),  64'(2'b10));
        chk({tag, ".rst_state"},  64'(o_state),   64'(ST_INT));
        chk({tag, ".rst_errcnt"}, 64'(o_err_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [1:0] frame_hdrs [7];
        int         kind;
        logic       v;
        logic [63:0] d;
        logic [7:0]  c;

        frame_hdrs = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 64'h0;
        tx_ctrl  = 8'h0;

        // Power-on reset
        do_reset("por");

        // Legal frame: I S D D D T I
        obs_hdr.delete();
        step("frame_i", 1'b1, IDLE_WORD, 8'hFF);
        step("frame_s", 1'b1, 64'hD5555555555555FB, 8'h01);
        for (int i = 0; i < 3; i++) step("frame_d", 1'b1, 64'h0123456789ABCDEF, 8'h00);
        step("frame_t", 1'b1, 64'hFD06050403020100, 8'h80);
        step("frame_i", 1'b1, IDLE_WORD, 8'hFF);
        flush(2);
        chk("frame.hdr_count", 64'(obs_hdr.size()), 64'd7);
        for (int i = 0; i < 7; i++)
            if (i < obs_hdr.size()) chk($sformatf("frame.hdr%0d", i), 64'(obs_hdr[i]), 64'(frame_hdrs[i]));
        chk("frame.errcnt", 64'(o_err_cnt), 64'd0);

        // Illegal: S then I -> error block, then S recovers
        do_reset("ill");
        step("ill_s", 1'b1, 64'h1122334455667FB, 8'h01);
        step("ill_i", 1'b1, IDLE_WORD, 8'hFF);
        flush(2);
        chk("ill.state",  64'(o_state),   64'(ST_E));
        chk("ill.block",  o_block,        ERR_BLOCK);
        chk("ill.errcnt", 64'(o_err_cnt), 64'd1);
        step("rec_s", 1'b1, 64'hAABBCCDDEEFF00FB, 8'h01);
        flush(2);
        chk("rec.state", 64'(o_state), 64'(ST_S));

        // T followed by D, and S followed by S
        step("td_d", 1'b1, 64'h1, 8'h00);
        step("td_t", 1'b1, 64'hFD00000000000000, 8'h80);
        step("td_d2", 1'b1, 64'h2, 8'h00);
        step("ss_s1", 1'b1, 64'h00000000000000FB, 8'h01);
        step("ss_s2", 1'b1, 64'h00000000000001FB, 8'h01);

        // Pause of three cycles in the middle of a D stream
        send("pz_i", K_I);
        send("pz_s", K_S);
        send("pz_d", K_D);
        send("pz_d", K_D);
        for (int i = 0; i < 3; i++) step("pz_hold", 1'b0, 64'hDEAD, 8'h00);
        send("pz_d", K_D);
        send("pz_t", K_T);
        send("pz_i", K_I);
        flush(2);

        // Error counter wrap: 256 illegal words
        do_reset("wrap");
        for (int i = 0; i < 256; i++) step("wrap_x", 1'b1, {$urandom, $urandom}, 8'h5A);
        flush(2);
        chk("wrap.errcnt", 64'(o_err_cnt), 64'd0);
        chk("wrap.state",  64'(o_state),   64'(ST_E));

        // Reset in the middle of a frame, then a D word
        send("mid_i", K_I);
        send("mid_s", K_S);
        send("mid_d", K_D);
        do_reset("mid");
        send("mid_post_d", K_D);
        flush(2);
        chk("mid.state",  64'(o_state),  64'(ST_E));
        chk("mid.block",  o_block,       ERR_BLOCK);
        chk("mid.header", 64'(o_header), 64'(2'b10));

        // Randomized stream with pauses, biased towards legal frames
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 12) == 0)
                kind = K_X;
            else if (m_state == ST_S || m_state == ST_D)
                kind = ($urandom_range(0, 3) == 0) ? K_T : K_D;
            else
                kind = ($urandom_range(0, 1) == 0) ? K_S : K_I;
            make_word(kind, d, c);
            step("rnd", v, d, c);
        end
        flush(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
